// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller: one outstanding req/ack transaction to the backing memory.
// Optional watchdog abort is built when REFILL_TIMEOUT_EN is defined.
module cache_refill_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       miss_valid,
  input  logic       miss_rw,
  input  logic [1:0] miss_addr,
  input  logic [1:0] miss_wdata,
  output logic       miss_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_addr,
  output logic [1:0] mem_wdata,
  input  logic       mem_ack,
  input  logic [1:0] mem_rdata,
  output logic       resp_valid,
  output logic       resp_rw,
  output logic [1:0] resp_addr,
  output logic [1:0] resp_data,
  output logic       resp_err,
  output logic [7:0] miss_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_rw;
  logic [1:0] r_addr;
  logic [1:0] r_wdata;
  logic       r_resp_rw;
  logic [1:0] r_resp_addr;
  logic [1:0] r_resp_data;
  logic       r_resp_err;
  logic [7:0] r_cnt;
  logic       w_accept;
  logic       w_done_ok;
  logic       w_timeout;

  assign miss_ready = (r_state == S_IDLE) & ena & ~rst;
  assign w_accept   = miss_valid & miss_ready;
  assign w_done_ok  = (r_state == S_MEM) & mem_ack;

`ifdef REFILL_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_tmo;

  // Abort on the cycle the counter would reach TIMEOUT; a same-cycle ack wins.
  assign w_timeout = (r_state == S_MEM) & ~mem_ack & (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= 8'd0;
    end else if (w_accept) begin
      r_tmo <= 8'd0;
    end else if ((r_state == S_MEM) && !mem_ack) begin
      r_tmo <= r_tmo + 8'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_MEM;
      S_MEM:   if (w_done_ok || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rw        <= 1'b0;
      r_addr      <= 2'd0;
      r_wdata     <= 2'd0;
      r_resp_rw   <= 1'b0;
      r_resp_addr <= 2'd0;
      r_resp_data <= 2'd0;
      r_resp_err  <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rw    <= miss_rw;
        r_addr  <= miss_addr;
        r_wdata <= miss_wdata;
        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
      if (w_done_ok) begin
        r_resp_rw   <= r_rw;
        r_resp_addr <= r_addr;
        r_resp_data <= r_rw ? r_wdata : mem_rdata;
        r_resp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_resp_rw   <= r_rw;
        r_resp_addr <= r_addr;
        r_resp_data <= 2'd0;
        r_resp_err  <= 1'b1;
      end
    end
  end

  // Memory-side fields come straight from the latch, so they stay stable throughout MEM.
  assign mem_req    = (r_state == S_MEM);
  assign mem_we     = (r_state == S_MEM) & r_rw;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rw    = r_resp_rw;
  assign resp_addr  = r_resp_addr;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign miss_cnt   = r_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl (TIMEOUT=3).
// Watchdog scenarios run only when REFILL_TIMEOUT_EN is defined.
module tb_cache_refill_ctrl;

  logic       clk = 1'b0;
  logic       rst, ena, miss_valid, miss_rw;
  logic [1:0] miss_addr, miss_wdata;
  logic       miss_ready, mem_req, mem_we;
  logic [1:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic [1:0] mem_rdata;
  logic       resp_valid, resp_rw, resp_err;
  logic [1:0] resp_addr, resp_data;
  logic [7:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  cache_refill_ctrl #(.TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .miss_valid(miss_valid), .miss_rw(miss_rw), .miss_addr(miss_addr),
    .miss_wdata(miss_wdata), .miss_ready(miss_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rw(resp_rw), .resp_addr(resp_addr),
    .resp_data(resp_data), .resp_err(resp_err), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request from IDLE; ack_cycle=0 means never ack.
  task automatic txn(input string tag, input logic rw, input logic [1:0] addr,
                     input logic [1:0] wd, input int ack_cycle, input logic [1:0] rd,
                     input int exp_req, input logic exp_err, input logic [1:0] exp_data);
    int n = 0;
    int budget = 0;
    check({tag, "_ready"}, miss_ready, 1);
    miss_valid = 1'b1; miss_rw = rw; miss_addr = addr; miss_wdata = wd;
    tick();
    miss_valid = 1'b0;
    exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    while (mem_req && budget < 40) begin
      n++;
      check({tag, "_mem_we"}, mem_we, rw);
      check({tag, "_mem_addr"}, mem_addr, addr);
      check({tag, "_mem_wdata"}, mem_wdata, wd);
      check({tag, "_busy"}, miss_ready, 0);
      if (n == ack_cycle) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end
      tick();
      mem_ack = 1'b0;
      budget++;
    end
    if (budget >= 40) check({tag, "_budget"}, mem_req, 0);
    check({tag, "_req_cycles"}, n, exp_req);
    check({tag, "_resp_valid"}, resp_valid, 1);
    check({tag, "_resp_rw"}, resp_rw, rw);
    check({tag, "_resp_addr"}, resp_addr, addr);
    check({tag, "_resp_data"}, resp_data, exp_data);
    check({tag, "_resp_err"}, resp_err, exp_err);
    check({tag, "_cnt"}, miss_cnt, exp_cnt);
    tick();
    check({tag, "_resp_drop"}, resp_valid, 0);
    check({tag, "_hold_data"}, resp_data, exp_data);
    $display("txn %s rw=%0d addr=%0d req_cycles=%0d data=%0d err=%0d cnt=%0d",
             tag, rw, addr, n, resp_data, resp_err, miss_cnt);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; miss_valid = 1'b0; miss_rw = 1'b0;
    miss_addr = 2'd0; miss_wdata = 2'd0; mem_ack = 1'b0; mem_rdata = 2'd0;
    tick(); tick();
    check("rst_ready", miss_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_cnt", miss_cnt, 0);
    rst = 1'b0;
    #1;

    txn("rd_imm", 1'b0, 2'd2, 2'd0, 1, 2'd3, 1, 1'b0, 2'd3);
    txn("wr_dly4", 1'b1, 2'd1, 2'd2, 4, 2'd3, 4, 1'b0, 2'd2);

    // miss_valid held high: second acceptance three edges after the first
    miss_valid = 1'b1; miss_rw = 1'b0; miss_addr = 2'd3;
    tick();
    check("bp_acc1", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 2'd1;
    tick();
    mem_ack = 1'b0;
    check("bp_resp1", resp_valid, 1);
    check("bp_ready_resp", miss_ready, 0);
    tick();
    check("bp_idle_ready", miss_ready, 1);
    check("bp_idle_req", mem_req, 0);
    tick();
    check("bp_acc2", mem_req, 1);
    miss_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 2'd0;
    tick();
    mem_ack = 1'b0;
    check("bp_resp2_data", resp_data, 0);
    tick();
    exp_cnt += 2;
    check("bp_cnt", miss_cnt, exp_cnt);
    $display("txn back_pressure cnt=%0d", miss_cnt);

    ena = 1'b0; miss_valid = 1'b1;
    #1;
    check("ena0_ready", miss_ready, 0);
    tick(); tick();
    check("ena0_no_req", mem_req, 0);
    check("ena0_cnt", miss_cnt, exp_cnt);
    miss_valid = 1'b0; ena = 1'b1;
    $display("txn ena_low cnt=%0d", miss_cnt);

    // ena dropped while the transaction is in flight
    miss_valid = 1'b1; miss_rw = 1'b1; miss_addr = 2'd0; miss_wdata = 2'd1;
    tick();
    miss_valid = 1'b0; ena = 1'b0;
    exp_cnt++;
    tick();
    check("ena_mid_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 2'd2;
    tick();
    mem_ack = 1'b0;
    check("ena_mid_resp", resp_valid, 1);
    check("ena_mid_data", resp_data, 1);
    tick();
    check("ena_mid_ready_off", miss_ready, 0);
    ena = 1'b1;
    #1;
    check("ena_mid_ready_on", miss_ready, 1);
    $display("txn ena_mid data=%0d cnt=%0d", resp_data, miss_cnt);

`ifdef REFILL_TIMEOUT_EN
    txn("timeout", 1'b0, 2'd3, 2'd1, 0, 2'd0, 3, 1'b1, 2'd0);
    mem_ack = 1'b1; mem_rdata = 2'd3;
    tick();
    mem_ack = 1'b0;
    check("late_ack_resp", resp_valid, 0);
    check("late_ack_req", mem_req, 0);
    tick();
    check("late_ack_resp2", resp_valid, 0);
    $display("txn late_ack resp_valid=%0d", resp_valid);
    txn("ack_at_limit", 1'b0, 2'd1, 2'd0, 3, 2'd2, 3, 1'b0, 2'd2);
`endif

    // Reset pulsed during MEM
    miss_valid = 1'b1; miss_rw = 1'b0; miss_addr = 2'd1;
    tick();
    miss_valid = 1'b0;
    tick();
    check("rstmid_req_before", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_req", mem_req, 0);
    check("rstmid_resp", resp_valid, 0);
    check("rstmid_cnt", miss_cnt, 0);
    tick();
    check("rstmid_no_resp", resp_valid, 0);
    exp_cnt = 0;
    $display("txn reset_mid cnt=%0d", miss_cnt);
    txn("after_rst", 1'b0, 2'd1, 2'd0, 2, 2'd1, 2, 1'b0, 2'd1);

    // Saturation: 260 accepted requests in total
    for (int i = 1; i < 260; i++) begin
      miss_valid = 1'b1; miss_rw = 1'b0; miss_addr = 2'(i);
      tick();
      miss_valid = 1'b0;
      mem_ack = 1'b1; mem_rdata = 2'd0;
      tick();
      mem_ack = 1'b0;
      tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (i == 254) check("sat_at_255", miss_cnt, exp_cnt);
    end
    check("sat_final", miss_cnt, 255);
    $display("txn saturation cnt=%0d", miss_cnt);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
